cdc_reg_responder: RTL and testbench

Application-side command responder sitting on the byte-stream side of the USB CDC function. Consumes bytes the host sends (the CDC OUT stream) and answers on the CDC IN stream. Implements a tiny read/write register protocol so the host can drive control outputs, read back inputs and read an ID byte. One response byte per completed command; at most one command in flight.

---
 rtl/cdc_reg_responder.sv | 177 +++++++++++++++++
 tb/tb_cdc_reg_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_reg_responder.sv
// rtl/cdc_reg_responder.sv - byte-stream register command responder for the CDC data path
module cdc_reg_responder #(
    parameter int          TIMEOUT_CYCLES = 48000,
    parameter logic [7:0]  ID_BYTE        = 8'h5B
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] gpio_i,
    output logic [7:0] ctrl0_o,
    output logic [7:0] ctrl1_o,
    output logic [7:0] err_cnt_o
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GET_DATA, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      addr_q, addr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      err_q, err_d;
    logic [7:0]      regs_q [6];
    logic [7:0]      regs_d [6];
    logic [7:0]      sync1_q, sync1_d;
    logic [7:0]      sync2_q, sync2_d;

    logic            rx_hs, tx_hs, cmd_bad, err_inc;
    logic [7:0]      rd_data;

    assign rx_hs   = rx_valid_i & rx_ready_o;
    assign tx_hs   = tx_valid_q & tx_ready_i;
    assign cmd_bad = |rx_data_i[6:3];

    always_comb begin
        case (rx_data_i[2:0])
            3'd0:    rd_data = regs_q[0];
            3'd1:    rd_data = regs_q[1];
            3'd2:    rd_data = regs_q[2];
            3'd3:    rd_data = regs_q[3];
            3'd4:    rd_data = regs_q[4];
            3'd5:    rd_data = regs_q[5];
            3'd6:    rd_data = sync2_q;
            default: rd_data = ID_BYTE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    state_d = (cmd_bad || !rx_data_i[7]) ? S_RESP : S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                // A data byte arriving on the final allowed cycle still completes the write
                if (rx_hs) begin
                    state_d = S_RESP;
                end else if (timer_q == TMAX) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (tx_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        regs_d     = regs_q;
        err_inc    = 1'b0;
        sync1_d    = gpio_i;
        sync2_d    = sync1_q;
        case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    if (cmd_bad) begin
                        tx_data_d  = 8'hEE;
                        tx_valid_d = 1'b1;
                        err_inc    = 1'b1;
                    end else if (!rx_data_i[7]) begin
                        tx_data_d  = rd_data;
                        tx_valid_d = 1'b1;
                    end else begin
                        addr_d  = rx_data_i[2:0];
                        timer_d = '0;
                    end
                end
            end
            S_GET_DATA: begin
                if (rx_hs) begin
                    tx_valid_d = 1'b1;
                    if (addr_q <= 3'd5) begin
                        for (int i = 0; i < 6; i++) begin
                            if (addr_q == 3'(i)) begin
                                regs_d[i] = rx_data_i;
                            end
                        end
                        tx_data_d = 8'hA5;
                    end else begin
                        tx_data_d = 8'hEE;
                        err_inc   = 1'b1;
                    end
                end else if (timer_q == TMAX) begin
                    err_inc = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                if (tx_hs) begin
                    tx_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            timer_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 8'h00;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            addr_q     <= addr_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        rx_ready_o = (state_q != S_RESP);
        tx_data_o  = tx_data_q;
        tx_valid_o = tx_valid_q;
        ctrl0_o    = regs_q[0];
        ctrl1_o    = regs_q[1];
        err_cnt_o  = err_q;
    end

endmodule

// File: tb/tb_cdc_reg_responder.sv
// tb/tb_cdc_reg_responder.sv - bench for cdc_reg_responder against a transaction-level register model
module tb_cdc_reg_responder;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] gpio;
    logic [7:0] ctrl0, ctrl1, err_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl_regs [6];
    logic [7:0] mdl_gpio;
    logic [7:0] mdl_err;

    cdc_reg_responder #(.TIMEOUT_CYCLES(T), .ID_BYTE(8'h5B)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .gpio_i     (gpio),
        .ctrl0_o    (ctrl0),
        .ctrl1_o    (ctrl1),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) mdl_regs[i] = 8'h00;
        mdl_err = 8'h00;
    endtask

    task automatic model_err();
        if (mdl_err != 8'hFF) mdl_err = mdl_err + 8'd1;
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [7:0] d);
        int n;
        n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("tx_resp_timeout", 32'd0, 32'd1);
        d = tx_data;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic [7:0] c, input logic [7:0] dat);
        logic [7:0] exp, got;
        logic [2:0] a;
        a = c[2:0];
        if (c[6:3] != 4'd0) begin
            exp = 8'hEE;
            model_err();
        end else if (!c[7]) begin
            exp = (a < 6) ? mdl_regs[a] : (a == 3'd6) ? mdl_gpio : 8'h5B;
        end else if (a < 6) begin
            mdl_regs[a] = dat;
            exp = 8'hA5;
        end else begin
            exp = 8'hEE;
            model_err();
        end
        send_byte(c);
        if (c[7] && c[6:3] == 4'd0) send_byte(dat);
        get_resp(got);
        check({tag, "_resp"}, {24'd0, got}, {24'd0, exp});
        check({tag, "_ctrl0"}, {24'd0, ctrl0}, {24'd0, mdl_regs[0]});
        check({tag, "_ctrl1"}, {24'd0, ctrl1}, {24'd0, mdl_regs[1]});
        check({tag, "_err"}, {24'd0, err_cnt}, {24'd0, mdl_err});
    endtask

    initial begin
        logic [7:0] c, got;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; gpio = 8'h00;
        mdl_gpio = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_ctrl0", {24'd0, ctrl0}, 32'h00);
        check("rst_err", {24'd0, err_cnt}, 32'h00);

        do_txn("id_read", 8'h07, 8'h00);
        do_txn("wr_r0", 8'h80, 8'h3C);
        do_txn("rd_r0", 8'h00, 8'h00);
        do_txn("bad_cmd", 8'h48, 8'h00);
        do_txn("wr_id", 8'h87, 8'h11);
        do_txn("id_again", 8'h07, 8'h00);

        // Data byte withheld: exactly T cycles in GET_DATA before the timeout fires
        send_byte(8'h81);
        repeat (T - 1) begin
            @(negedge clk);
            check("tmo_no_tx", {31'd0, tx_valid}, 32'd0);
        end
        check("tmo_err_before", {24'd0, err_cnt}, {24'd0, mdl_err});
        @(negedge clk);
        model_err();
        check("tmo_err_after", {24'd0, err_cnt}, {24'd0, mdl_err});
        check("tmo_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("tmo_rx_ready", {31'd0, rx_ready}, 32'd1);
        do_txn("tmo_idle_read", 8'h00, 8'h00);

        // Data byte on the last allowed cycle completes the write
        send_byte(8'h81);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h6D);
        mdl_regs[1] = 8'h6D;
        get_resp(got);
        check("late_wr_resp", {24'd0, got}, 32'hA5);
        check("late_wr_ctrl1", {24'd0, ctrl1}, 32'h6D);
        check("late_wr_err", {24'd0, err_cnt}, {24'd0, mdl_err});

        // Response stalled by tx_ready low; pending rx byte must be held off
        send_byte(8'h00);
        rx_data  = 8'h07;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_tx_data", {24'd0, tx_data}, {24'd0, mdl_regs[0]});
            check("stall_rx_ready", {31'd0, rx_ready}, 32'd0);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        check("stall_release_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("stall_release_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        get_resp(got);
        check("stall_next_resp", {24'd0, got}, 32'h5B);

        gpio = 8'hC3;
        mdl_gpio = 8'hC3;
        repeat (2) @(negedge clk);
        do_txn("gpio_read", 8'h06, 8'h00);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = {5'b00000, 3'($urandom)};
                4, 5, 6, 7: c = {5'b10000, 3'($urandom)};
                default: begin
                    c = 8'($urandom);
                    if (c[6:3] == 4'd0) c[3] = 1'b1;
                end
            endcase
            if (i == 30) begin
                gpio = 8'($urandom);
                mdl_gpio = gpio;
                repeat (3) @(negedge clk);
            end
            do_txn("rand", c, 8'($urandom));
        end

        for (int i = 0; i < 300; i++) begin
            c = 8'($urandom);
            if (c[6:3] == 4'd0) c[4] = 1'b1;
            do_txn("sat", c, 8'h00);
        end
        check("sat_final", {24'd0, err_cnt}, 32'hFF);

        // Reset in the middle of a write command
        send_byte(8'h80);
        rst = 1'b1;
        #1;
        check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("mid_rst_ctrl0", {24'd0, ctrl0}, 32'h00);
        check("mid_rst_ctrl1", {24'd0, ctrl1}, 32'h00);
        check("mid_rst_err", {24'd0, err_cnt}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_txn("post_rst_r0", 8'h00, 8'h00);
        do_txn("post_rst_r1", 8'h01, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
